// File: rtl/i2s_frame_sequencer.sv
// I2S frame sequencer: serialises stereo tx pairs onto sdout and deserialises sdin,
// with all timing taken from the shared clock-generator sequence counter.
module i2s_frame_sequencer #(
    parameter int SEQ_WIDTH    = 11,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [SEQ_WIDTH-1:0]    seq_i,
    input  logic                    enable_i,
    input  logic [SAMPLE_WIDTH-1:0] tx_left_i,
    input  logic [SAMPLE_WIDTH-1:0] tx_right_i,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    output logic                    sdout_o,
    input  logic                    sdin_i,
    output logic [SAMPLE_WIDTH-1:0] rx_left_o,
    output logic [SAMPLE_WIDTH-1:0] rx_right_o,
    output logic                    rx_valid_o,
    output logic                    underrun_o,
    input  logic                    underrun_clr_i
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    hold_full_q;
    logic [SAMPLE_WIDTH-1:0] hold_left_q;
    logic [SAMPLE_WIDTH-1:0] hold_right_q;
    logic [SAMPLE_WIDTH-1:0] tx_left_q;
    logic [SAMPLE_WIDTH-1:0] tx_right_q;
    logic [SAMPLE_WIDTH-1:0] rx_sh_left_q;
    logic [SAMPLE_WIDTH-1:0] rx_sh_right_q;
    logic [SAMPLE_WIDTH-1:0] rx_left_q;
    logic [SAMPLE_WIDTH-1:0] rx_right_q;
    logic                    sdout_q;
    logic                    rx_valid_q;
    logic                    underrun_q;

    logic [8:0]              pos;
    logic                    fs;
    logic                    last;
    logic                    launch;
    logic                    capture;
    logic                    chan;
    logic [4:0]              bidx;
    logic                    in_slot;
    logic                    active;
    logic                    accepting;
    logic                    fs_load;
    logic                    ur_set;
    logic [SAMPLE_WIDTH-1:0] tx_sel;
    logic [4:0]              tx_idx;
    logic                    tx_bit_d;
    logic [SAMPLE_WIDTH-1:0] rx_sh_left_d;
    logic [SAMPLE_WIDTH-1:0] rx_sh_right_d;
    logic                    unused_seq;

    // Only the low nine bits of the counter define a frame.
    assign pos        = seq_i[8:0];
    assign unused_seq = ^seq_i[SEQ_WIDTH-1:9];
    assign fs         = (pos == 9'd0);
    assign last       = (pos == 9'd511);
    assign launch     = (pos[2:0] == 3'd0);
    assign capture    = (pos[2:0] == 3'd4);
    assign chan       = pos[8];
    assign bidx       = pos[7:3];
    assign in_slot    = (bidx != 5'd0) && (int'(bidx) <= SAMPLE_WIDTH);

    assign active     = (state_q == RUN) || (state_q == DRAIN);
    assign accepting  = (state_q == SYNC) || (state_q == RUN);
    assign fs_load    = fs && ((state_q == RUN) || ((state_q == SYNC) && enable_i));
    assign ur_set     = fs_load && !hold_full_q && !tx_valid_i;

    // Slot b carries sample bit [SAMPLE_WIDTH-b]; slot 0 is the I2S one-bit delay.
    assign tx_sel        = chan ? tx_right_q : tx_left_q;
    assign tx_idx        = 5'(SAMPLE_WIDTH) - bidx;
    assign tx_bit_d      = in_slot ? tx_sel[tx_idx] : 1'b0;
    assign rx_sh_left_d  = SAMPLE_WIDTH'({rx_sh_left_q, sdin_i});
    assign rx_sh_right_d = SAMPLE_WIDTH'({rx_sh_right_q, sdin_i});

    assign tx_ready_o = accepting && !hold_full_q;
    assign sdout_o    = sdout_q;
    assign rx_left_o  = rx_left_q;
    assign rx_right_o = rx_right_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            hold_full_q   <= 1'b0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            tx_left_q     <= '0;
            tx_right_q    <= '0;
            rx_sh_left_q  <= '0;
            rx_sh_right_q <= '0;
            rx_left_q     <= '0;
            rx_right_q    <= '0;
            sdout_q       <= 1'b0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            unique case (state_q)
                IDLE:  if (enable_i) state_q <= SYNC;
                SYNC:  if (!enable_i) state_q <= IDLE;
                       else if (fs) state_q <= RUN;
                RUN:   if (!enable_i) state_q <= DRAIN;
                DRAIN: if (last) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (active) begin
                if (launch) sdout_q <= tx_bit_d;
            end else begin
                sdout_q <= 1'b0;
            end

            if (active && capture && in_slot) begin
                if (chan) rx_sh_right_q <= rx_sh_right_d;
                else      rx_sh_left_q  <= rx_sh_left_d;
            end

            if (active && last) begin
                rx_left_q  <= rx_sh_left_q;
                rx_right_q <= rx_sh_right_q;
                rx_valid_q <= 1'b1;
            end

            // A pair offered on the frame-start cycle with holding empty skips holding.
            if (fs_load) begin
                if (hold_full_q) begin
                    tx_left_q   <= hold_left_q;
                    tx_right_q  <= hold_right_q;
                    hold_full_q <= 1'b0;
                end else if (tx_valid_i) begin
                    tx_left_q  <= tx_left_i;
                    tx_right_q <= tx_right_i;
                end else begin
                    tx_left_q  <= '0;
                    tx_right_q <= '0;
                end
            end else if (tx_valid_i && tx_ready_o) begin
                hold_left_q  <= tx_left_i;
                hold_right_q <= tx_right_i;
                hold_full_q  <= 1'b1;
            end

            if (ur_set)              underrun_q <= 1'b1;
            else if (underrun_clr_i) underrun_q <= 1'b0;
        end
    end
endmodule
